apb_mem_responder: RTL and testbench
====================================

Name: apb_mem_responder

Overview:
- APB completer (responder end) that answers transfers issued by the team's APB master.
- Contains a word-addressed register/memory array with a programmable number of wait states.
- Signals PSLVERR for misaligned or out-of-range accesses.
- Used as the bus-side target in APB benches and as a small config-register bank in designs.

Parameters:
- ADDR_WIDTH, 8: PADDR width (byte address).
- DATA_WIDTH, 32: PWDATA/PRDATA width. Must be a multiple of 8.
- DEPTH, 16: number of DATA_WIDTH words in the array. Word index = PADDR[ADDR_WIDTH-1:2].
- WAIT_STATES, 1: access-phase cycles with PREADY=0 before PREADY=1. Range 0..15.

Ports:
- PCLK  input  1  bus clock; all state updates on rising edge.
- PRESET  input  1  asynchronous, active-high reset.
- PSEL  input  1  slave select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1=write, 0=read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PRDATA  output  DATA_WIDTH  read data, valid only while PREADY=1 on a read.
- PREADY  output  1  transfer-complete strobe.
- PSLVERR  output  1  error response, valid only while PREADY=1.

Behaviour:
- Clock and reset: one clock, PCLK. PRESET is asynchronous and active-high.
- Reset values (asserted immediately on PRESET, independent of PCLK):
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - FSM=IDLE, wait counter=0, all array words=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge where PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE, PWDATA and compute err.
  - err = (PADDR[1:0]!=0) or (word index >= DEPTH).
  - If WAIT_STATES=0, go to RESP. Otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT:
  - Decrement the counter each edge with PSEL=1 and PENABLE=1.
  - At counter=0, go to RESP.
- RESP:
  - PREADY=1 (registered) for exactly one cycle.
  - PSLVERR=err.
  - PRDATA = array[index] on a read with no error; 0 otherwise.
  - At the edge ending RESP: a write with no error commits to the array. Then go to IDLE, and PREADY, PSLVERR and PRDATA return to 0.
- Latency: setup at cycle T0; PREADY=1 in cycle T0+1+WAIT_STATES.
- Latched address and data are used for the whole transfer. Input changes after setup are ignored.
- Abort: if PSEL=0 in WAIT or RESP, go to IDLE at the next edge, with no array write and PREADY=0.
- Back-to-back transfers: a new setup phase is accepted in the cycle immediately after RESP.
- Error handling: a write with an error leaves the array unchanged. A read with an error returns PRDATA=0.
- Reads return the value after any write completed in an earlier transfer. There is no same-cycle read/write hazard, since one transfer is in flight at a time.
- PENABLE=1 while in IDLE (no setup seen) is ignored and produces no response.
- Reset mid-transfer: the transfer is dropped and the pending write is lost.

Optional Feature:
- Macro: APB_PSTRB_EN.
- Defined:
  - Adds port PSTRB, input, width DATA_WIDTH/8, latched at setup.
  - A write updates only byte lanes whose strobe bit is 1.
  - PSTRB=0 on a write is a legal no-op with PSLVERR=0.
  - PSTRB is ignored on reads.
- Undefined: no PSTRB port; every write updates the full word.

Test Plan:
1. WAIT_STATES=1, write addr 0 ← 17, then read addr 0 -> PREADY rises in the 2nd access cycle; PRDATA=32'd17, PSLVERR=0.
2. Write addr 8 ← 32'h00415042 ("APB"), read addr 8 -> 32'h00415042; read addr 4 -> 32'h0.
3. Write addr 8'h40 (index 16 with DEPTH=16) ← 32'hDEADBEEF -> PSLVERR=1 with PREADY. Then read 8'h40 -> PRDATA=0, PSLVERR=1. Read addr 0 still returns 17.
4. Read addr 8'h02 (misaligned) -> PSLVERR=1, PRDATA=0. Then a back-to-back read of addr 0 in the next cycle -> 17, PSLVERR=0.
5. Assert PRESET while in WAIT during a write to addr 12 -> PREADY=0 with no clock edge needed. After release, read addr 12 and addr 0 -> both 0.
6. With APB_PSTRB_EN: write addr 12 ← 32'hFFFFFFFF with PSTRB=4'hF, then write 32'h0 with PSTRB=4'b0010, then read addr 12 -> 32'hFFFF00FF. Also sweep WAIT_STATES=0 and WAIT_STATES=3 -> PREADY in access cycle 1 and 4 respectively.

Source files
------------

// File: rtl/apb_mem_responder.sv
// apb_mem_responder: APB completer with a word array, fixed wait states and PSLVERR; byte strobes when APB_PSTRB_EN is defined
module apb_mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic                  ready_q, ready_d;
    logic                  slverr_q, slverr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [NB-1:0]         in_strb;

`ifdef APB_PSTRB_EN
    assign in_strb = PSTRB;
`else
    assign in_strb = '1;
`endif

    function automatic logic addr_err(logic [ADDR_WIDTH-1:0] a);
        return a[1:0] != 2'b00 || int'(a[ADDR_WIDTH-1:2]) >= DEPTH;
    endfunction

    // transfer sequencing: capture at setup, count wait states, one-cycle registered response
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;
        if (state_q == IDLE && PSEL && !PENABLE) begin
            idx_d   = PADDR[IW+1:2];
            write_d = PWRITE;
            wdata_d = PWDATA;
            strb_d  = in_strb;
            err_d   = addr_err(PADDR);
            cnt_d   = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
            state_d = WAIT_STATES == 0 ? RESP : WAIT;
        end else if (state_q == WAIT && !PSEL) begin
            state_d = IDLE;
        end else if (state_q == WAIT && PENABLE) begin
            state_d = cnt_q == 4'd0 ? RESP : WAIT;
            cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        if (state_d == RESP && state_q != RESP) begin
            ready_d  = 1'b1;
            slverr_d = err_d;
            rdata_d  = (write_d || err_d) ? '0 : mem_q[idx_d];
        end
    end

    // a completing error-free write merges its enabled byte lanes into the array
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (state_q == RESP && PSEL && write_q && !err_q)
            for (int b = 0; b < NB; b++)
                if (strb_q[b]) mem_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
    end

    // all state, including the array, clears immediately on reset
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign PREADY  = ready_q;
    assign PSLVERR = slverr_q;
    assign PRDATA  = rdata_q;
endmodule

// File: tb/tb_apb_mem_responder.sv
// tb_apb_mem_responder: table, directed and random checks of three responders with 1, 0 and 3 wait states
module tb_apb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  psel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = 4'hF;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [3][16];

    always #5 clk = ~clk;

    apb_mem_responder #(.WAIT_STATES(1)) dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_mem_responder #(.WAIT_STATES(0)) dut1 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb_mem_responder #(.WAIT_STATES(3)) dut2 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    function automatic int ws(int k);
        return k == 0 ? 1 : k == 1 ? 0 : 3;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) model[k][i] = '0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            psel = '0;
            penable = 1'b0;
        end
    endtask

    task automatic xfer(int k, bit wr, logic [7:0] a, logic [31:0] wd, logic [3:0] st, bit scr,
                        output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        psel = '0;
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        pstrb = st;
        @(negedge clk);
        penable = 1'b1;
        lat = 0;
        rd = 'x;
        err = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            if (pready[k]) begin
                lat = n;
                rd = prdata[k];
                err = pslverr[k];
                break;
            end
            if (scr) begin
                paddr = 8'($urandom);
                pwdata = $urandom;
                pwrite = 1'($urandom);
                pstrb = 4'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic run(int k, bit wr, logic [7:0] a, logic [31:0] wd, logic [3:0] st, bit scr,
                       logic [31:0] exp_rd, bit exp_err, string name);
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [3:0]  eff;
        xfer(k, wr, a, wd, st, scr, rd, err, lat);
        check({name, " latency"}, 32'(lat), 32'(ws(k) + 1));
        check({name, " pslverr"}, {31'b0, err}, {31'b0, exp_err});
        check({name, " prdata"}, rd, exp_rd);
`ifdef APB_PSTRB_EN
        eff = st;
`else
        eff = 4'hF;
`endif
        if (wr && !exp_err)
            for (int b = 0; b < 4; b++)
                if (eff[b]) model[k][a[5:2]][8*b +: 8] = wd[8*b +: 8];
    endtask

    function automatic bit bad_addr(logic [7:0] a);
        return a[1:0] != 2'b00 || a[7:2] >= 6'd16;
    endfunction

    task automatic run_model(int k, bit wr, logic [7:0] a, logic [31:0] wd, logic [3:0] st, bit scr, string name);
        bit e;
        e = bad_addr(a);
        run(k, wr, a, wd, st, scr, (!wr && !e) ? model[k][a[5:2]] : 32'h0, e, name);
    endtask

    typedef struct {
        int          k;
        bit          wr;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vt [10];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 1'b1, 8'h00, 32'd17,        32'h0,        1'b0};
        vt[1] = '{0, 1'b0, 8'h00, 32'h0,         32'd17,       1'b0};
        vt[2] = '{0, 1'b1, 8'h08, 32'h00415042,  32'h0,        1'b0};
        vt[3] = '{0, 1'b0, 8'h08, 32'h0,         32'h00415042, 1'b0};
        vt[4] = '{0, 1'b0, 8'h04, 32'h0,         32'h0,        1'b0};
        vt[5] = '{0, 1'b1, 8'h40, 32'hDEADBEEF,  32'h0,        1'b1};
        vt[6] = '{0, 1'b0, 8'h40, 32'h0,         32'h0,        1'b1};
        vt[7] = '{0, 1'b0, 8'h00, 32'h0,         32'd17,       1'b0};
        vt[8] = '{0, 1'b0, 8'h02, 32'h0,         32'h0,        1'b1};
        vt[9] = '{0, 1'b0, 8'h00, 32'h0,         32'd17,       1'b0};
        clear_model();

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset pready%0d", k), {31'b0, pready[k]}, 32'h0);
            check($sformatf("reset pslverr%0d", k), {31'b0, pslverr[k]}, 32'h0);
            check($sformatf("reset prdata%0d", k), prdata[k], 32'h0);
        end
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 10; i++)
            run(vt[i].k, vt[i].wr, vt[i].a, vt[i].wd, 4'hF, 1'b0, vt[i].exp_rd, vt[i].exp_err, $sformatf("vec%0d", i));
        idle(2);

        psel = 3'b010;
        penable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("penable in idle", {31'b0, pready[1]}, 32'h0);
        end
        idle(1);

        run(2, 1'b1, 8'h04, 32'h11, 4'hF, 1'b0, 32'h0, 1'b0, "pre-abort write ws3");
        @(negedge clk);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h55;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        check("abort wait pready", {31'b0, pready[2]}, 32'h0);
        psel = '0;
        repeat (4) begin
            @(negedge clk);
            check("abort wait idle pready", {31'b0, pready[2]}, 32'h0);
        end
        run(2, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h11, 1'b0, "after wait abort");

        run(1, 1'b1, 8'h04, 32'h22, 4'hF, 1'b0, 32'h0, 1'b0, "pre-abort write ws0");
        @(negedge clk);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h77;
        @(negedge clk);
        penable = 1'b1;
        check("abort resp pready", {31'b0, pready[1]}, 32'h1);
        psel = '0;
        @(negedge clk);
        check("abort resp drop", {31'b0, pready[1]}, 32'h0);
        run(1, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h22, 1'b0, "after resp abort");

        run(1, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h22, 1'b0, "ws0 latency read");
        run(2, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0, 32'h11, 1'b0, "ws3 latency read");

`ifdef APB_PSTRB_EN
        run(0, 1'b1, 8'h0C, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b0, "strb full write");
        run(0, 1'b1, 8'h0C, 32'h0, 4'b0010, 1'b0, 32'h0, 1'b0, "strb lane1 write");
        run(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, 32'hFFFF00FF, 1'b0, "strb read");
        run(0, 1'b1, 8'h0C, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, "strb zero write");
        run(0, 1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, 32'hFFFF00FF, 1'b0, "strb zero read");
`endif

        for (int i = 0; i < 200; i++) begin
            int          k;
            bit          wr;
            logic [7:0]  a;
            k = $urandom_range(2);
            wr = 1'($urandom);
            a = $urandom_range(3) != 0 ? {2'b00, 4'($urandom), 2'b00} : 8'($urandom);
            run_model(k, wr, a, $urandom, 4'($urandom), 1'($urandom), $sformatf("rand%0d", i));
            if ($urandom_range(1) != 0) idle(1 + $urandom_range(1));
        end
        idle(2);

        run(2, 1'b1, 8'h00, 32'd17, 4'hF, 1'b0, 32'h0, 1'b0, "ws3 write 0");
        @(negedge clk);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hAAAA5555; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset in wait pready", {31'b0, pready[2]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        psel = '0;
        penable = 1'b0;
        clear_model();
        run(2, 1'b0, 8'h0C, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, "post reset read 12");
        run(2, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, "post reset read 0");
        idle(1);

        run(0, 1'b1, 8'h00, 32'd17, 4'hF, 1'b0, 32'h0, 1'b0, "ws1 write 0");
        idle(1);
        @(negedge clk);
        psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
        @(negedge clk);
        penable = 1'b1;
        repeat (ws(0)) @(negedge clk);
        check("resp before reset pready", {31'b0, pready[0]}, 32'h1);
        check("resp before reset prdata", prdata[0], 32'd17);
        rst = 1'b1;
        #1;
        check("async reset pready", {31'b0, pready[0]}, 32'h0);
        check("async reset prdata", prdata[0], 32'h0);
        check("async reset pslverr", {31'b0, pslverr[0]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        psel = '0;
        penable = 1'b0;
        clear_model();
        run(0, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, "post async reset read 0");
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
